sprite_motion_update: RTL and testbench

- Player-sprite state stage directly upstream of the frame sequencer that issues DrawMif draw requests.
- On each frame-update request it samples the four push-buttons and advances horizontal position, jump/gravity physics and animation frame.
- Presents xSprite/ySprite/spriteId, which stay stable between updates, and an explicit done pulse that replaces fixed-count waiting in the sequencer.
- Coordinates use LT24 portrait space, 240 x 320.

---
 rtl/sprite_motion_update_pkg.sv | 36 +++
 rtl/sprite_motion_update_if.sv | 29 ++
 rtl/sprite_motion_update_key_synchroniser.sv | 33 +++
 rtl/sprite_motion_update.sv | 195 +++++++++++++++++++
 tb/tb_sprite_motion_update.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sprite_motion_update_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_motion_update_pkg
// Brief    : Shared sprite ids, LT24 screen size, key bits and FSM encoding.
// Revision : 1.0
// ============================================================================
package sprite_motion_update_pkg;

    localparam int c_SCREEN_W = 240;
    localparam int c_SCREEN_H = 320;

    // DrawMif ROM ids; background and floor live in the same id space.
    localparam logic [3:0] c_SPR_IDLE  = 4'd0;
    localparam logic [3:0] c_SPR_RUN0  = 4'd1;
    localparam logic [3:0] c_SPR_RUN1  = 4'd2;
    localparam logic [3:0] c_SPR_RUN2  = 4'd3;
    localparam logic [3:0] c_SPR_JUMP  = 4'd4;
    localparam logic [3:0] c_SPR_FLOOR = 4'd5;
    localparam logic [3:0] c_SPR_BG    = 4'd15;

    localparam int c_KEY_RIGHT   = 0;
    localparam int c_KEY_LEFT    = 1;
    localparam int c_KEY_JUMP    = 2;
    localparam int c_KEY_RESPAWN = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_MOVE_X  = 3'd2,
        ST_MOVE_Y  = 3'd3,
        ST_ANIMATE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_motion_update_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_motion_update_if
// Brief    : Update request, buttons and sprite state bundle.
// Revision : 1.0
// ============================================================================
interface sprite_motion_update_if;

    logic              update;
    logic        [3:0] keys;
    logic              done;
    logic              busy;
    logic signed [8:0] xSprite;
    logic signed [9:0] ySprite;
    logic        [3:0] spriteId;
    logic              onGround;

    modport master (
        output update, keys,
        input  done, busy, xSprite, ySprite, spriteId, onGround
    );

    modport slave (
        input  update, keys,
        output done, busy, xSprite, ySprite, spriteId, onGround
    );

endinterface
`default_nettype wire

// File: rtl/sprite_motion_update_key_synchroniser.sv
`default_nettype none
// ============================================================================
// Module   : key_synchroniser
// Brief    : Parameterised-width two-flop synchroniser with a reset level.
// Revision : 1.0
// ============================================================================
module key_synchroniser #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= {WIDTH{RST_VAL}};
            r_sync <= {WIDTH{RST_VAL}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sprite_motion_update.sv
`default_nettype none
// ============================================================================
// Module   : sprite_motion_update
// Brief    : Per-frame player sprite update: buttons, jump physics, animation.
// Revision : 1.0
// ============================================================================
module sprite_motion_update
    import sprite_motion_update_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SCREEN_W = c_SCREEN_W,
    parameter int X_START  = 104,
    parameter int GROUND_Y = 240,
    parameter int X_STEP   = 4,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 15
) (
    input  logic                   clock,
    input  logic                   reset_n,
    sprite_motion_update_if.slave  bus
);

    localparam logic signed [9:0]  c_X_MAX     = 10'(SCREEN_W - SPRITE_W);
    localparam logic signed [9:0]  c_X_STEP    = 10'(X_STEP);
    localparam logic signed [8:0]  c_X_START   = 9'(X_START);
    localparam logic signed [9:0]  c_GROUND_Y  = 10'(GROUND_Y);
    localparam logic signed [10:0] c_GROUND_Y11 = 11'(GROUND_Y);
    localparam logic signed [5:0]  c_JUMP_VY   = 6'(-JUMP_VEL);
    localparam logic signed [6:0]  c_GRAVITY   = 7'(GRAVITY);
    localparam logic signed [6:0]  c_MAX_FALL  = 7'(MAX_FALL);

    logic [3:0]         w_keys_sync;
    logic [0:0]         w_upd_sync;
    logic               r_upd_prev;
    logic               w_upd_rise;
    logic [3:0]         w_pressed;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_busy;
    logic               w_done;

    logic [3:0]         r_key_latch;
    logic signed [8:0]  r_x;
    logic signed [9:0]  r_y;
    logic signed [5:0]  r_vy;
    logic               r_on_ground;
    logic [3:0]         r_sprite_id;
    logic [1:0]         r_anim_phase;

    key_synchroniser #(.WIDTH(4), .RST_VAL(1'b1)) u_key_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (bus.keys),
        .o_q     (w_keys_sync)
    );

    key_synchroniser #(.WIDTH(1), .RST_VAL(1'b0)) u_upd_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (bus.update),
        .o_q     (w_upd_sync)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_upd_prev <= 1'b0;
        else          r_upd_prev <= w_upd_sync[0];
    end

    assign w_upd_rise = w_upd_sync[0] & ~r_upd_prev;
    assign w_pressed  = ~w_keys_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Edges seen outside IDLE are dropped, which also makes a held level count once.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE:    if (w_upd_rise) w_state_next = ST_SAMPLE;
            ST_SAMPLE:  begin w_busy = 1'b1; w_state_next = ST_MOVE_X;  end
            ST_MOVE_X:  begin w_busy = 1'b1; w_state_next = ST_MOVE_Y;  end
            ST_MOVE_Y:  begin w_busy = 1'b1; w_state_next = ST_ANIMATE; end
            ST_ANIMATE: begin w_busy = 1'b1; w_state_next = ST_DONE;    end
            ST_DONE:    begin w_done = 1'b1; w_state_next = ST_IDLE;    end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Horizontal step in 10-bit signed so the clamp sees the true overshoot.
    logic               w_right;
    logic               w_left;
    logic               w_respawn;
    logic               w_moving;
    logic signed [9:0]  w_x_wide;
    logic signed [9:0]  w_x_right;
    logic signed [9:0]  w_x_left;
    logic signed [8:0]  w_x_next;

    assign w_right   = r_key_latch[c_KEY_RIGHT];
    assign w_left    = r_key_latch[c_KEY_LEFT];
    assign w_respawn = r_key_latch[c_KEY_RESPAWN];
    assign w_moving  = (w_right ^ w_left) & ~w_respawn;
    assign w_x_wide  = {r_x[8], r_x};
    assign w_x_right = w_x_wide + c_X_STEP;
    assign w_x_left  = w_x_wide - c_X_STEP;

    always_comb begin
        w_x_next = r_x;
        if (w_right && !w_left)
            w_x_next = (w_x_right > c_X_MAX) ? c_X_MAX[8:0] : w_x_right[8:0];
        else if (w_left && !w_right)
            w_x_next = (w_x_left < 10'sd0) ? 9'sd0 : w_x_left[8:0];
    end

    // A jump take-off shares the airborne path, so gravity applies in that step too.
    logic               w_jump_start;
    logic               w_apply_y;
    logic signed [5:0]  w_vy_eff;
    logic signed [10:0] w_y_sum;
    logic signed [6:0]  w_vy_grav;
    logic               w_land;

    assign w_jump_start = r_on_ground & r_key_latch[c_KEY_JUMP];
    assign w_apply_y    = ~w_respawn & (w_jump_start | ~r_on_ground);
    assign w_vy_eff     = w_jump_start ? c_JUMP_VY : r_vy;
    assign w_y_sum      = {r_y[9], r_y} + {{5{w_vy_eff[5]}}, w_vy_eff};
    assign w_vy_grav    = {w_vy_eff[5], w_vy_eff} + c_GRAVITY;
    assign w_land       = (w_y_sum >= c_GROUND_Y11);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_latch  <= 4'd0;
            r_x          <= c_X_START;
            r_y          <= c_GROUND_Y;
            r_vy         <= 6'sd0;
            r_on_ground  <= 1'b1;
            r_sprite_id  <= c_SPR_IDLE;
            r_anim_phase <= 2'd0;
        end else begin
            case (r_state)
                ST_SAMPLE: r_key_latch <= w_pressed;
                ST_MOVE_X: begin
                    if (w_respawn) begin
                        r_x         <= c_X_START;
                        r_y         <= c_GROUND_Y;
                        r_vy        <= 6'sd0;
                        r_on_ground <= 1'b1;
                    end else begin
                        r_x <= w_x_next;
                    end
                end
                ST_MOVE_Y: begin
                    if (w_apply_y) begin
                        if (w_land) begin
                            r_y         <= c_GROUND_Y;
                            r_vy        <= 6'sd0;
                            r_on_ground <= 1'b1;
                        end else begin
                            r_y         <= w_y_sum[9:0];
                            r_vy        <= (w_vy_grav > c_MAX_FALL) ? c_MAX_FALL[5:0] : w_vy_grav[5:0];
                            r_on_ground <= 1'b0;
                        end
                    end
                end
                ST_ANIMATE: begin
                    if (!r_on_ground) begin
                        r_sprite_id <= c_SPR_JUMP;
                    end else if (w_moving) begin
                        r_sprite_id  <= c_SPR_RUN0 + {2'b00, r_anim_phase};
                        r_anim_phase <= (r_anim_phase == 2'd2) ? 2'd0 : r_anim_phase + 2'd1;
                    end else begin
                        r_sprite_id  <= c_SPR_IDLE;
                        r_anim_phase <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done     = w_done;
    assign bus.busy     = w_busy;
    assign bus.xSprite  = r_x;
    assign bus.ySprite  = r_y;
    assign bus.spriteId = r_sprite_id;
    assign bus.onGround = r_on_ground;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_motion_update
// Brief    : Directed self-checking bench for sprite_motion_update.
// Revision : 1.0
// ============================================================================
module tb_sprite_motion_update;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // Expected y for the take-off update followed by 24 key-free updates.
    int jump_y [25] = '{228, 217, 207, 198, 190, 183, 177, 172, 168, 165, 163, 162, 162,
                        163, 165, 168, 172, 177, 183, 190, 198, 207, 217, 228, 240};

    always #10 clock = ~clock;

    sprite_motion_update_if bus ();

    sprite_motion_update dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey, input int eid, input int eg);
        chk({tag, "_x"},  int'(bus.xSprite), ex);
        chk({tag, "_y"},  int'(bus.ySprite), ey);
        chk({tag, "_id"}, int'(bus.spriteId), eid);
        chk({tag, "_gnd"}, int'(bus.onGround), eg);
    endtask

    // Raise update at a falling edge and count rising edges until done is seen.
    task automatic do_update(output int lat);
        bus.update = 1'b1;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!bus.done && lat < 20);
        chk("upd_done", int'(bus.done), 1);
        bus.update = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int lat;
        int n;
        int ex;

        bus.update = 1'b0;
        bus.keys   = 4'hF;
        repeat (3) @(negedge clock);
        chk_pos("reset", 104, 240, 0, 1);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_busy", int'(bus.busy), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Two synchroniser edges plus five FSM edges.
        do_update(lat);
        chk("latency", lat, 7);
        chk_pos("idle", 104, 240, 0, 1);

        bus.keys = 4'b1110;
        for (int k = 1; k <= 30; k++) begin
            do_update(lat);
            ex = (104 + 4 * k > 208) ? 208 : 104 + 4 * k;
            chk("right_x", int'(bus.xSprite), ex);
            chk("right_id", int'(bus.spriteId), 1 + ((k - 1) % 3));
        end

        bus.keys = 4'b0111;
        do_update(lat);
        chk_pos("respawn1", 104, 240, 0, 1);

        bus.keys = 4'b1101;
        for (int k = 1; k <= 27; k++) begin
            do_update(lat);
            ex = (104 - 4 * k < 0) ? 0 : 104 - 4 * k;
            chk("left_x", int'(bus.xSprite), ex);
            chk("left_id", int'(bus.spriteId), 1 + ((k - 1) % 3));
        end

        bus.keys = 4'b0111;
        do_update(lat);
        bus.keys = 4'b1100;
        do_update(lat);
        chk_pos("both", 104, 240, 0, 1);

        bus.keys = 4'b1011;
        do_update(lat);
        chk_pos("jump0", 104, jump_y[0], 4, 0);
        bus.keys = 4'b1111;
        for (int i = 1; i <= 24; i++) begin
            do_update(lat);
            chk("jump_y", int'(bus.ySprite), jump_y[i]);
            chk("jump_id", int'(bus.spriteId), (i == 24) ? 0 : 4);
            chk("jump_gnd", int'(bus.onGround), (i == 24) ? 1 : 0);
        end

        bus.update = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge clock);
            if (bus.done) n++;
        end
        chk("held_high_dones", n, 1);
        bus.update = 1'b0;
        repeat (4) @(negedge clock);

        // A one-cycle low glitch creates a second edge that lands while busy.
        bus.update = 1'b1;
        n = 0;
        while (!bus.busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("busy_seen", int'(bus.busy), 1);
        bus.update = 1'b0;
        @(negedge clock);
        bus.update = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.done) n++;
        end
        chk("busy_edge_dones", n, 1);
        bus.update = 1'b0;
        repeat (4) @(negedge clock);

        bus.keys = 4'b1110;
        do_update(lat);
        do_update(lat);
        bus.keys = 4'b1010;
        do_update(lat);
        chk_pos("runjump", 116, 228, 4, 0);
        bus.keys = 4'b1111;
        do_update(lat);
        chk("air_y", int'(bus.ySprite), 217);
        bus.keys = 4'b0111;
        do_update(lat);
        chk_pos("respawn_air", 104, 240, 0, 1);
        bus.keys = 4'b1111;
        do_update(lat);
        chk_pos("after_respawn", 104, 240, 0, 1);

        bus.keys = 4'b1011;
        do_update(lat);
        bus.keys = 4'b1111;
        do_update(lat);
        chk("prejump_y", int'(bus.ySprite), 217);
        bus.update = 1'b1;
        n = 0;
        while (!bus.busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("busy_seen2", int'(bus.busy), 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_pos("midreset", 104, 240, 0, 1);
        chk("midreset_done", int'(bus.done), 0);
        chk("midreset_busy", int'(bus.busy), 0);
        bus.update = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        do_update(lat);
        chk("latency2", lat, 7);
        chk_pos("post_reset", 104, 240, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
